// File: rtl/breakout_pkg.sv
// Shared constants, index widths and hit-handshake state encoding for the
// breakout block-state storage.
package breakout_pkg;

    localparam int BLOCKS_PER_ROW = 13;
    localparam int NUM_ROWS       = 16;
    localparam int ROW_W          = 4;
    localparam int COL_W          = 4;

    typedef enum logic [1:0] {
        HIT_IDLE    = 2'd0,
        HIT_CHECK   = 2'd1,
        HIT_ACK     = 2'd2,
        HIT_WAITLOW = 2'd3
    } hit_state_e;

    // Limits a requested fill row count to the number of rows that exist.
    function automatic logic [4:0] clamp_rows(input logic [4:0] req, input logic [4:0] max_rows);
        if (req > max_rows) begin
            clamp_rows = max_rows;
        end else begin
            clamp_rows = req;
        end
    endfunction

endpackage

// File: rtl/block_state_mem.sv
// Breakout block presence storage: per-row display scan, level loading,
// four-phase hit handshake and live block counter.
module block_state_mem
    import breakout_pkg::*;
#(
    parameter int BLOCKS_PER_ROW = breakout_pkg::BLOCKS_PER_ROW,
    parameter int NUM_ROWS       = breakout_pkg::NUM_ROWS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      new_frame,
    input  logic                      go_next_line,
    output logic [BLOCKS_PER_ROW-1:0] block_line_state,
    input  logic                      level_load,
    input  logic [4:0]                level_rows,
    input  logic                      hit_req,
    input  logic [ROW_W-1:0]          hit_row,
    input  logic [COL_W-1:0]          hit_col,
    output logic                      hit_ack,
    output logic                      hit_was_present,
    output logic [7:0]                blocks_remaining,
    output logic                      level_clear
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    logic [BLOCKS_PER_ROW-1:0] rows_r [NUM_ROWS];
    logic [BLOCKS_PER_ROW-1:0] rows_s [NUM_ROWS];
    logic [ROW_W-1:0]          ptr_r;
    logic [ROW_W-1:0]          ptr_s;
    logic                      done_r;
    logic                      done_s;
    logic                      loaded_r;
    logic                      loaded_s;
    logic [7:0]                count_s;
    logic [4:0]                fill_rows_s;
    logic [BLOCKS_PER_ROW-1:0] row_word_s;
    logic [BLOCKS_PER_ROW-1:0] shifted_s;
    logic                      present_s;
    logic                      clear_s;
    hit_state_e                state_r;
    logic [ROW_W-1:0]          hit_row_r;
    logic [COL_W-1:0]          hit_col_r;

    // Next storage, counter and scan pointer; a level load beats any pending clear.
    always_comb begin
        fill_rows_s = clamp_rows(level_rows, 5'(NUM_ROWS));
        row_word_s  = rows_r[hit_row_r];
        shifted_s   = row_word_s >> hit_col_r;
        present_s   = (hit_col_r < COL_W'(BLOCKS_PER_ROW)) && shifted_s[0];
        clear_s     = (state_r == HIT_CHECK) && !level_load && present_s;
        rows_s      = rows_r;
        count_s     = blocks_remaining;
        loaded_s    = loaded_r;

        if (level_load) begin
            for (int i = 0; i < NUM_ROWS; i++) begin
                rows_s[i] = (5'(i) < fill_rows_s) ? {BLOCKS_PER_ROW{1'b1}} : {BLOCKS_PER_ROW{1'b0}};
            end
            count_s  = 8'(fill_rows_s) * 8'(BLOCKS_PER_ROW);
            loaded_s = (fill_rows_s != 5'd0);
        end else if (clear_s) begin
            rows_s[hit_row_r] = row_word_s & ~({{(BLOCKS_PER_ROW-1){1'b0}}, 1'b1} << hit_col_r);
            if (blocks_remaining != 8'd0) begin
                count_s = blocks_remaining - 8'd1;
            end else begin
                count_s = blocks_remaining;
            end
        end else begin
            count_s = blocks_remaining;
        end

        if (new_frame) begin
            ptr_s  = {ROW_W{1'b0}};
            done_s = 1'b0;
        end else if (go_next_line && !done_r) begin
            if (ptr_r == LAST_ROW) begin
                ptr_s  = ptr_r;
                done_s = 1'b1;
            end else begin
                ptr_s  = ptr_r + {{(ROW_W-1){1'b0}}, 1'b1};
                done_s = 1'b0;
            end
        end else begin
            ptr_s  = ptr_r;
            done_s = done_r;
        end
    end

    // Storage, pointer and count registers; display word follows next-state so it never lags a change.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ROWS; i++) begin
                rows_r[i] <= {BLOCKS_PER_ROW{1'b0}};
            end
            ptr_r            <= {ROW_W{1'b0}};
            done_r           <= 1'b0;
            loaded_r         <= 1'b0;
            blocks_remaining <= 8'd0;
            block_line_state <= {BLOCKS_PER_ROW{1'b0}};
            level_clear      <= 1'b0;
        end else begin
            rows_r           <= rows_s;
            ptr_r            <= ptr_s;
            done_r           <= done_s;
            loaded_r         <= loaded_s;
            blocks_remaining <= count_s;
            block_line_state <= done_s ? {BLOCKS_PER_ROW{1'b0}} : rows_s[ptr_s];
            level_clear      <= loaded_s && (count_s == 8'd0);
        end
    end

    // Hit handshake FSM; a level load during CHECK/ACK drops back to IDLE so a held request is re-checked.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= HIT_IDLE;
            hit_row_r       <= {ROW_W{1'b0}};
            hit_col_r       <= {COL_W{1'b0}};
            hit_ack         <= 1'b0;
            hit_was_present <= 1'b0;
        end else begin
            hit_ack         <= 1'b0;
            hit_was_present <= 1'b0;
            case (state_r)
                HIT_IDLE: begin
                    if (hit_req) begin
                        hit_row_r <= hit_row;
                        hit_col_r <= hit_col;
                        state_r   <= HIT_CHECK;
                    end else begin
                        state_r   <= HIT_IDLE;
                    end
                end
                HIT_CHECK: begin
                    if (level_load) begin
                        state_r <= HIT_IDLE;
                    end else begin
                        hit_ack         <= 1'b1;
                        hit_was_present <= present_s;
                        state_r         <= HIT_ACK;
                    end
                end
                HIT_ACK: begin
                    if (level_load) begin
                        state_r <= HIT_IDLE;
                    end else begin
                        state_r <= HIT_WAITLOW;
                    end
                end
                HIT_WAITLOW: begin
                    if (!hit_req) begin
                        state_r <= HIT_IDLE;
                    end else begin
                        state_r <= HIT_WAITLOW;
                    end
                end
                default: begin
                    state_r <= HIT_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_state_mem.sv
// Directed bench for block_state_mem: expected hit responses are queued by the
// stimulus and consumed by an acknowledge monitor.
module tb_block_state_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_frame;
    logic        go_next_line;
    logic [12:0] block_line_state;
    logic        level_load;
    logic [4:0]  level_rows;
    logic        hit_req;
    logic [3:0]  hit_row;
    logic [3:0]  hit_col;
    logic        hit_ack;
    logic        hit_was_present;
    logic [7:0]  blocks_remaining;
    logic        level_clear;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [8:0]  exp_q [$];
    logic [8:0]  mon_e;

    block_state_mem dut (
        .clk              (clk),
        .rst              (rst),
        .new_frame        (new_frame),
        .go_next_line     (go_next_line),
        .block_line_state (block_line_state),
        .level_load       (level_load),
        .level_rows       (level_rows),
        .hit_req          (hit_req),
        .hit_row          (hit_row),
        .hit_col          (hit_col),
        .hit_ack          (hit_ack),
        .hit_was_present  (hit_was_present),
        .blocks_remaining (blocks_remaining),
        .level_clear      (level_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every acknowledge must match the oldest queued expectation.
    always @(negedge clk) begin
        if (hit_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ack: got ack present=%0b count=%0d expected no ack at %0t",
                         hit_was_present, blocks_remaining, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_present", {31'd0, hit_was_present}, {31'd0, mon_e[8]});
                check("ack_count", {24'd0, blocks_remaining}, {24'd0, mon_e[7:0]});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic ld, input logic nf, input logic gnl, input logic [4:0] rows);
        level_load   = ld;
        new_frame    = nf;
        go_next_line = gnl;
        level_rows   = rows;
        tick(1);
        level_load   = 1'b0;
        new_frame    = 1'b0;
        go_next_line = 1'b0;
    endtask

    task automatic wait_ack();
        int k;
        k = 0;
        while (hit_ack !== 1'b1 && k < 20) begin
            tick(1);
            k++;
        end
        if (hit_ack !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout: got no ack expected ack within 20 cycles at %0t", $time);
        end
    endtask

    task automatic do_hit(input logic [3:0] r, input logic [3:0] c, input logic p,
                          input logic [7:0] cnt, input int hold);
        exp_q.push_back({p, cnt});
        hit_row = r;
        hit_col = c;
        hit_req = 1'b1;
        wait_ack();
        tick(hold);
        hit_req = 1'b0;
        tick(3);
    endtask

    initial begin
        rst = 1'b1; new_frame = 1'b0; go_next_line = 1'b0; level_load = 1'b0;
        level_rows = 5'd0; hit_req = 1'b0; hit_row = 4'd0; hit_col = 4'd0;
        tick(2);
        check("rst_line", {19'd0, block_line_state}, 32'h0);
        check("rst_count", {24'd0, blocks_remaining}, 32'd0);
        check("rst_clear", {31'd0, level_clear}, 32'd0);
        check("rst_ack", {30'd0, hit_ack, hit_was_present}, 32'd0);
        rst = 1'b0;
        pulse(1'b0, 1'b1, 1'b0, 5'd0);
        tick(1);
        check("post_rst_line", {19'd0, block_line_state}, 32'h0);

        pulse(1'b1, 1'b0, 1'b0, 5'd16);
        check("load16_count", {24'd0, blocks_remaining}, 32'd208);
        check("load16_clear", {31'd0, level_clear}, 32'd0);
        pulse(1'b0, 1'b1, 1'b0, 5'd0);
        tick(1);
        check("load16_line", {19'd0, block_line_state}, 32'h1FFF);

        pulse(1'b1, 1'b0, 1'b0, 5'd3);
        check("load3_count", {24'd0, blocks_remaining}, 32'd39);
        pulse(1'b0, 1'b1, 1'b0, 5'd0);
        tick(1);
        check("load3_row0", {19'd0, block_line_state}, 32'h1FFF);
        pulse(1'b0, 1'b0, 1'b1, 5'd0); tick(1);
        check("load3_row1", {19'd0, block_line_state}, 32'h1FFF);
        pulse(1'b0, 1'b0, 1'b1, 5'd0); tick(1);
        check("load3_row2", {19'd0, block_line_state}, 32'h1FFF);
        pulse(1'b0, 1'b0, 1'b1, 5'd0); tick(1);
        check("load3_row3", {19'd0, block_line_state}, 32'h0);
        pulse(1'b0, 1'b0, 1'b1, 5'd0);
        pulse(1'b0, 1'b1, 1'b1, 5'd0); tick(1);
        check("frame_wins", {19'd0, block_line_state}, 32'h1FFF);
        for (int i = 0; i < 16; i++) pulse(1'b0, 1'b0, 1'b1, 5'd0);
        tick(1);
        check("done_line", {19'd0, block_line_state}, 32'h0);
        pulse(1'b1, 1'b0, 1'b0, 5'd16); tick(1);
        check("done_after_load", {19'd0, block_line_state}, 32'h0);
        pulse(1'b0, 1'b1, 1'b0, 5'd0); tick(1);
        check("refresh_line", {19'd0, block_line_state}, 32'h1FFF);

        pulse(1'b0, 1'b0, 1'b1, 5'd0);
        pulse(1'b0, 1'b0, 1'b1, 5'd0);
        do_hit(4'd2, 4'd5, 1'b1, 8'd207, 0);
        check("hit_line", {19'd0, block_line_state}, 32'h1FDF);
        do_hit(4'd2, 4'd5, 1'b0, 8'd207, 0);
        do_hit(4'd2, 4'd14, 1'b0, 8'd207, 0);
        do_hit(4'd2, 4'd13, 1'b0, 8'd207, 0);
        do_hit(4'd15, 4'd12, 1'b1, 8'd206, 0);
        check("other_row_line", {19'd0, block_line_state}, 32'h1FDF);
        do_hit(4'd3, 4'd0, 1'b1, 8'd205, 5);
        check("held_count", {24'd0, blocks_remaining}, 32'd205);

        pulse(1'b1, 1'b0, 1'b0, 5'd20); tick(1);
        check("clamp_count", {24'd0, blocks_remaining}, 32'd208);
        check("clamp_line", {19'd0, block_line_state}, 32'h1FFF);
        pulse(1'b1, 1'b0, 1'b0, 5'd0); tick(1);
        check("load0_count", {24'd0, blocks_remaining}, 32'd0);
        check("load0_clear", {31'd0, level_clear}, 32'd0);
        check("load0_line", {19'd0, block_line_state}, 32'h0);

        pulse(1'b1, 1'b0, 1'b0, 5'd1);
        check("load1_count", {24'd0, blocks_remaining}, 32'd13);
        for (int c = 0; c < 13; c++) begin
            do_hit(4'd0, 4'(c), 1'b1, 8'(12 - c), 0);
            if (c == 11) check("clear_before_last", {31'd0, level_clear}, 32'd0);
        end
        check("level_clear", {31'd0, level_clear}, 32'd1);
        do_hit(4'd0, 4'd0, 1'b0, 8'd0, 0);
        check("no_underflow", {24'd0, blocks_remaining}, 32'd0);
        pulse(1'b1, 1'b0, 1'b0, 5'd1);
        check("reload_clear", {31'd0, level_clear}, 32'd0);
        check("reload_count", {24'd0, blocks_remaining}, 32'd13);

        exp_q.push_back({1'b1, 8'd12});
        hit_row = 4'd0; hit_col = 4'd0; hit_req = 1'b1;
        tick(1);
        pulse(1'b1, 1'b0, 1'b0, 5'd1);
        check("abort_no_ack", {31'd0, hit_ack}, 32'd0);
        check("abort_count", {24'd0, blocks_remaining}, 32'd13);
        wait_ack();
        hit_req = 1'b0;
        tick(3);
        check("reservice_count", {24'd0, blocks_remaining}, 32'd12);

        hit_row = 4'd0; hit_col = 4'd1; hit_req = 1'b1;
        tick(1);
        rst = 1'b1;
        tick(1);
        check("rst_abort_ack", {31'd0, hit_ack}, 32'd0);
        check("rst_abort_count", {24'd0, blocks_remaining}, 32'd0);
        rst = 1'b0; hit_req = 1'b0;
        tick(4);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
